// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline.
//
// Captures decoded control, register addresses, read data, immediate and PC+4 from ID
// and presents them as the stage-3 signals used by the EX-stage forwarder and ALU.
// Detects a load-use hazard against the instruction currently in EX. When one is seen
// it raises stall, which freezes PC and IF/ID, and it loads a bubble into EX. A taken
// branch or jump (Flush) kills the ID instruction. Flush takes priority over the stall.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   *2 inputs                stage-2 (ID) control, addresses, data, immediate, PC+4
//   UsesRt2                  ID instruction reads rt as a source operand
//   Flush                    kill the instruction in ID
//   stall                    combinational; holds PC and IF/ID for one cycle
//   *3 outputs               registered stage-3 (EX) copies of the ID fields
//   valid3                   EX slot holds a real instruction
//   stall_count              saturating count of stall cycles, cleared only by reset
module id_ex_pipe_reg #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWrite2,
    input  logic            MemRead2,
    input  logic            MemWrite2,
    input  logic            MemtoReg2,
    input  logic            ALUSrc2,
    input  logic [3:0]      ALUOp2,
    input  logic            UsesRt2,
    input  logic [AW-1:0]   Rreg_addr12,
    input  logic [AW-1:0]   Rreg_addr22,
    input  logic [AW-1:0]   Wreg_addr2,
    input  logic [DW-1:0]   Rdata12,
    input  logic [DW-1:0]   Rdata22,
    input  logic [DW-1:0]   imm2,
    input  logic [DW-1:0]   pc4_2,
    input  logic            Flush,
    output logic            stall,
    output logic            RegWrite3,
    output logic            MemRead3,
    output logic            MemWrite3,
    output logic            MemtoReg3,
    output logic            ALUSrc3,
    output logic [3:0]      ALUOp3,
    output logic [AW-1:0]   Rreg_addr13,
    output logic [AW-1:0]   Rreg_addr23,
    output logic [AW-1:0]   Wreg_addr3,
    output logic [DW-1:0]   Rdata12_3,
    output logic [DW-1:0]   Rdata22_3,
    output logic [DW-1:0]   imm3,
    output logic [DW-1:0]   pc4_3,
    output logic            valid3,
    output logic [CNTW-1:0] stall_count
);

    logic haz;
    logic bubble;

    // A load in EX whose destination feeds the ID instruction cannot be forwarded in
    // time. $zero is never a real dependency.
    always_comb begin
        haz = valid3 && MemRead3 && (Wreg_addr3 != '0) &&
              ((Wreg_addr3 == Rreg_addr12) || (UsesRt2 && (Wreg_addr3 == Rreg_addr22)));
        stall  = haz && !Flush;
        bubble = Flush || haz;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite3   <= 1'b0;
            MemRead3    <= 1'b0;
            MemWrite3   <= 1'b0;
            MemtoReg3   <= 1'b0;
            ALUSrc3     <= 1'b0;
            ALUOp3      <= '0;
            Rreg_addr13 <= '0;
            Rreg_addr23 <= '0;
            Wreg_addr3  <= '0;
            Rdata12_3   <= '0;
            Rdata22_3   <= '0;
            imm3        <= '0;
            pc4_3       <= '0;
            valid3      <= 1'b0;
        end else if (bubble) begin
            RegWrite3   <= 1'b0;
            MemRead3    <= 1'b0;
            MemWrite3   <= 1'b0;
            MemtoReg3   <= 1'b0;
            ALUSrc3     <= 1'b0;
            ALUOp3      <= '0;
            Rreg_addr13 <= '0;
            Rreg_addr23 <= '0;
            Wreg_addr3  <= '0;
            Rdata12_3   <= '0;
            Rdata22_3   <= '0;
            imm3        <= '0;
            pc4_3       <= '0;
            valid3      <= 1'b0;
        end else begin
            // A write to $zero would never be forwarded correctly, so drop it here.
            RegWrite3   <= RegWrite2 && (Wreg_addr2 != '0);
            MemRead3    <= MemRead2;
            MemWrite3   <= MemWrite2;
            MemtoReg3   <= MemtoReg2;
            ALUSrc3     <= ALUSrc2;
            ALUOp3      <= ALUOp2;
            Rreg_addr13 <= Rreg_addr12;
            Rreg_addr23 <= Rreg_addr22;
            Wreg_addr3  <= Wreg_addr2;
            Rdata12_3   <= Rdata12;
            Rdata22_3   <= Rdata22;
            imm3        <= imm2;
            pc4_3       <= pc4_2;
            valid3      <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

    logic        clk;
    logic        rst_n;
    logic        RegWrite2, MemRead2, MemWrite2, MemtoReg2, ALUSrc2, UsesRt2, Flush;
    logic [3:0]  ALUOp2;
    logic [4:0]  Rreg_addr12, Rreg_addr22, Wreg_addr2;
    logic [31:0] Rdata12, Rdata22, imm2, pc4_2;

    logic        stall, RegWrite3, MemRead3, MemWrite3, MemtoReg3, ALUSrc3, valid3;
    logic [3:0]  ALUOp3;
    logic [4:0]  Rreg_addr13, Rreg_addr23, Wreg_addr3;
    logic [31:0] Rdata12_3, Rdata22_3, imm3, pc4_3;
    logic [15:0] stall_count;

    // Narrow-counter copy so saturation is reachable in a short run.
    logic        s_stall, s_rw3, s_mr3, s_mw3, s_mtr3, s_as3, s_valid3;
    logic [3:0]  s_aluop3;
    logic [4:0]  s_ra13, s_ra23, s_wa3;
    logic [31:0] s_rd13, s_rd23, s_imm3, s_pc43;
    logic [3:0]  s_cnt;

    int total = 0;
    int bad   = 0;

    id_ex_pipe_reg u_dut (
        .clk(clk), .rst_n(rst_n),
        .RegWrite2(RegWrite2), .MemRead2(MemRead2), .MemWrite2(MemWrite2),
        .MemtoReg2(MemtoReg2), .ALUSrc2(ALUSrc2), .ALUOp2(ALUOp2), .UsesRt2(UsesRt2),
        .Rreg_addr12(Rreg_addr12), .Rreg_addr22(Rreg_addr22), .Wreg_addr2(Wreg_addr2),
        .Rdata12(Rdata12), .Rdata22(Rdata22), .imm2(imm2), .pc4_2(pc4_2), .Flush(Flush),
        .stall(stall), .RegWrite3(RegWrite3), .MemRead3(MemRead3), .MemWrite3(MemWrite3),
        .MemtoReg3(MemtoReg3), .ALUSrc3(ALUSrc3), .ALUOp3(ALUOp3),
        .Rreg_addr13(Rreg_addr13), .Rreg_addr23(Rreg_addr23), .Wreg_addr3(Wreg_addr3),
        .Rdata12_3(Rdata12_3), .Rdata22_3(Rdata22_3), .imm3(imm3), .pc4_3(pc4_3),
        .valid3(valid3), .stall_count(stall_count)
    );

    id_ex_pipe_reg #(.CNTW(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .RegWrite2(RegWrite2), .MemRead2(MemRead2), .MemWrite2(MemWrite2),
        .MemtoReg2(MemtoReg2), .ALUSrc2(ALUSrc2), .ALUOp2(ALUOp2), .UsesRt2(UsesRt2),
        .Rreg_addr12(Rreg_addr12), .Rreg_addr22(Rreg_addr22), .Wreg_addr2(Wreg_addr2),
        .Rdata12(Rdata12), .Rdata22(Rdata22), .imm2(imm2), .pc4_2(pc4_2), .Flush(Flush),
        .stall(s_stall), .RegWrite3(s_rw3), .MemRead3(s_mr3), .MemWrite3(s_mw3),
        .MemtoReg3(s_mtr3), .ALUSrc3(s_as3), .ALUOp3(s_aluop3),
        .Rreg_addr13(s_ra13), .Rreg_addr23(s_ra23), .Wreg_addr3(s_wa3),
        .Rdata12_3(s_rd13), .Rdata22_3(s_rd23), .imm3(s_imm3), .pc4_3(s_pc43),
        .valid3(s_valid3), .stall_count(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw, mr, mw, mtr, asrc;
        logic [3:0]  aluop;
        logic        urt;
        logic [4:0]  ra1, ra2, wa;
        logic [31:0] rd1;
        logic        fl;
        logic        e_stall;  // stall before the edge
        logic        e_cap;    // edge captures the ID instruction (else bubble)
        logic        e_rw;     // RegWrite3 after the edge
        logic [15:0] e_cnt;    // stall_count after the edge
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic rw, mr, mw, mtr, asrc, input logic [3:0] aluop,
                                input logic urt, input logic [4:0] ra1, ra2, wa,
                                input logic [31:0] rd1, input logic fl, e_stall, e_cap, e_rw,
                                input logic [15:0] e_cnt);
        vec_t v;
        v.rw = rw; v.mr = mr; v.mw = mw; v.mtr = mtr; v.asrc = asrc; v.aluop = aluop;
        v.urt = urt; v.ra1 = ra1; v.ra2 = ra2; v.wa = wa; v.rd1 = rd1; v.fl = fl;
        v.e_stall = e_stall; v.e_cap = e_cap; v.e_rw = e_rw; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input int idx);
        RegWrite2 = v.rw; MemRead2 = v.mr; MemWrite2 = v.mw; MemtoReg2 = v.mtr;
        ALUSrc2 = v.asrc; ALUOp2 = v.aluop; UsesRt2 = v.urt;
        Rreg_addr12 = v.ra1; Rreg_addr22 = v.ra2; Wreg_addr2 = v.wa;
        Rdata12 = v.rd1; Rdata22 = 32'h2000 + 32'(idx); imm2 = 32'h300 + 32'(idx);
        pc4_2 = 32'h400 + 32'(4 * idx); Flush = v.fl;
    endtask

    initial begin
        // rw mr mw mtr as op urt ra1 ra2 wa rd1 fl | stall cap rw cnt
        vecs[0]  = mk(1, 0, 0, 0, 0, 2, 1, 1, 2, 3, 32'h10, 0,  0, 1, 1, 0); // add $3,$1,$2
        vecs[1]  = mk(1, 1, 0, 1, 1, 0, 0, 1, 5, 5, 32'h100, 0, 0, 1, 1, 0); // lw $5
        vecs[2]  = mk(1, 0, 0, 0, 0, 2, 1, 5, 2, 6, 32'h55, 0,  1, 0, 0, 1); // rs use -> stall
        vecs[3]  = mk(1, 0, 0, 0, 0, 2, 1, 5, 2, 6, 32'h55, 0,  0, 1, 1, 1); // held, captured
        vecs[4]  = mk(1, 1, 0, 1, 1, 0, 0, 1, 5, 5, 32'h100, 0, 0, 1, 1, 1); // lw $5
        vecs[5]  = mk(1, 0, 0, 0, 0, 3, 0, 7, 5, 8, 32'h77, 0,  0, 1, 1, 1); // rt, UsesRt2=0
        vecs[6]  = mk(1, 1, 0, 1, 1, 0, 0, 1, 5, 5, 32'h100, 0, 0, 1, 1, 1); // lw $5
        vecs[7]  = mk(1, 0, 0, 0, 0, 3, 1, 7, 5, 8, 32'h77, 0,  1, 0, 0, 2); // rt, UsesRt2=1
        vecs[8]  = mk(1, 0, 0, 0, 0, 3, 1, 7, 5, 8, 32'h77, 0,  0, 1, 1, 2);
        vecs[9]  = mk(1, 1, 0, 1, 1, 0, 0, 1, 0, 0, 32'h100, 0, 0, 1, 0, 2); // lw $0
        vecs[10] = mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 9, 32'h0, 0,   0, 1, 1, 2); // reads $0
        vecs[11] = mk(1, 0, 0, 0, 0, 2, 1, 1, 2, 0, 32'h11, 0,  0, 1, 0, 2); // write $0
        vecs[12] = mk(1, 1, 0, 1, 1, 0, 0, 1, 5, 5, 32'h100, 0, 0, 1, 1, 2); // lw $5
        vecs[13] = mk(1, 0, 0, 0, 0, 2, 1, 5, 2, 6, 32'h55, 1,  0, 0, 0, 2); // haz + Flush
        vecs[14] = mk(1, 0, 0, 0, 0, 2, 1, 1, 2, 3, 32'h10, 1,  0, 0, 0, 2); // Flush only
        vecs[15] = mk(1, 1, 0, 1, 1, 0, 0, 1, 4, 4, 32'h100, 0, 0, 1, 1, 2); // lw $4
        vecs[16] = mk(1, 1, 0, 1, 1, 0, 0, 4, 6, 6, 32'h44, 0,  1, 0, 0, 3); // lw $6,0($4)
        vecs[17] = mk(1, 1, 0, 1, 1, 0, 0, 4, 6, 6, 32'h44, 0,  0, 1, 1, 3);
        vecs[18] = mk(1, 0, 0, 0, 0, 2, 1, 6, 2, 7, 32'h66, 0,  1, 0, 0, 4); // uses $6
        vecs[19] = mk(1, 0, 0, 0, 0, 2, 1, 6, 2, 7, 32'h66, 0,  0, 1, 1, 4);

        rst_n = 1'b0;
        drive(vecs[0], 0);
        #12;
        chk("reset_valid3", 64'(valid3), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_count", 64'(stall_count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            vec_t v;
            v = vecs[i];
            drive(v, i);
            #1;
            chk($sformatf("v%0d_stall", i), 64'(stall), 64'(v.e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid3", i), 64'(valid3), 64'(v.e_cap));
            chk($sformatf("v%0d_regwrite3", i), 64'(RegWrite3), 64'(v.e_rw));
            chk($sformatf("v%0d_ctrl3", i),
                64'({MemRead3, MemWrite3, MemtoReg3, ALUSrc3, ALUOp3}),
                v.e_cap ? 64'({v.mr, v.mw, v.mtr, v.asrc, v.aluop}) : 64'd0);
            chk($sformatf("v%0d_addr3", i), 64'({Rreg_addr13, Rreg_addr23, Wreg_addr3}),
                v.e_cap ? 64'({v.ra1, v.ra2, v.wa}) : 64'd0);
            chk($sformatf("v%0d_rdata12_3", i), 64'(Rdata12_3), v.e_cap ? 64'(v.rd1) : 64'd0);
            chk($sformatf("v%0d_data3", i), {Rdata22_3, imm3 ^ pc4_3},
                v.e_cap ? {32'h2000 + 32'(i), (32'h300 + 32'(i)) ^ (32'h400 + 32'(4 * i))}
                        : 64'd0);
            chk($sformatf("v%0d_count", i), 64'(stall_count), 64'(v.e_cnt));
        end
        chk("narrow_count_tracks", 64'(s_cnt), 64'd4);

        // Hold a self-dependent load in ID: EX alternates load / bubble, so every
        // second edge is a stall. 51 edges give 25 stalls and leave the load in EX.
        drive(mk(1, 1, 0, 1, 1, 0, 0, 5, 5, 5, 32'h5, 0, 0, 0, 0, 0), 30);
        repeat (51) @(posedge clk);
        #1;
        chk("sat_wide_count", 64'(stall_count), 64'd29);
        chk("sat_narrow_count", 64'(s_cnt), 64'hF);
        chk("pre_reset_stall", 64'(stall), 64'd1);
        @(posedge clk);
        #1;
        chk("sat_narrow_hold", 64'(s_cnt), 64'hF);
        chk("stall_one_cycle", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        chk("restall", 64'(stall), 64'd1);

        // Reset between edges must clear everything without a clock.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_stall", 64'(stall), 64'd0);
        chk("async_valid3", 64'(valid3), 64'd0);
        chk("async_count", 64'(stall_count), 64'd0);
        chk("async_narrow_count", 64'(s_cnt), 64'd0);
        chk("async_ctrl", 64'({RegWrite3, MemRead3, MemWrite3, MemtoReg3, ALUSrc3, ALUOp3,
                               Rreg_addr13, Rreg_addr23, Wreg_addr3}), 64'd0);
        chk("async_data", {Rdata12_3 | Rdata22_3, imm3 | pc4_3}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
